// File: rtl/processorci_core_controller_if.sv
// Host load port and core fetch/data bus signals of the core-side controller.
// The slave modport is the controller; the master modport is the host/core side.
interface processorci_core_controller_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 host_hold;
  logic                 host_we;
  logic [BUS_WIDTH-1:0] host_addr;
  logic [BUS_WIDTH-1:0] host_wdata;
  logic                 reset_core;

  logic                 core_read_memory;
  logic [BUS_WIDTH-1:0] core_address_memory;
  logic [BUS_WIDTH-1:0] core_read_data_memory;
  logic                 core_memory_response;

  logic                 core_read_memory_data;
  logic                 core_write_memory_data;
  logic [BUS_WIDTH-1:0] core_address_memory_data;
  logic [BUS_WIDTH-1:0] core_write_data_memory_data;
  logic [BUS_WIDTH-1:0] core_read_data_memory_data;
  logic                 core_memory_response_data;

  modport master (
    output host_hold, host_we, host_addr, host_wdata,
    output core_read_memory, core_address_memory,
    output core_read_memory_data, core_write_memory_data,
    output core_address_memory_data, core_write_data_memory_data,
    input  reset_core, core_read_data_memory, core_memory_response,
    input  core_read_data_memory_data, core_memory_response_data
  );

  modport slave (
    input  host_hold, host_we, host_addr, host_wdata,
    input  core_read_memory, core_address_memory,
    input  core_read_memory_data, core_write_memory_data,
    input  core_address_memory_data, core_write_data_memory_data,
    output reset_core, core_read_data_memory, core_memory_response,
    output core_read_data_memory_data, core_memory_response_data
  );
endinterface

// File: rtl/processorci_core_controller.sv
// Core reset sequencer plus a word memory shared by instruction fetch,
// data accesses and the host loader (host writes only while the core is in reset).
module processorci_core_controller #(
  parameter int BUS_WIDTH        = 32,
  parameter int WORD_SIZE_BY     = 4,
  parameter int RESET_CLK_CYCLES = 20,
  parameter int MEMORY_SIZE      = 4096
) (
  input logic                         clk,
  input logic                         reset_n,
  processorci_core_controller_if.slave bus
);
  localparam int WORDS = MEMORY_SIZE / WORD_SIZE_BY;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF   = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 0;
  localparam int CW    = (RESET_CLK_CYCLES > 1) ? $clog2(RESET_CLK_CYCLES + 1) : 1;
  localparam logic [BUS_WIDTH-1:0] MEM_LIMIT = BUS_WIDTH'(MEMORY_SIZE);

  typedef enum logic {ST_COUNT, ST_RUN} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_reset_core;
  logic [BUS_WIDTH-1:0] r_mem [WORDS];
  logic                 r_fetch_resp;
  logic [BUS_WIDTH-1:0] r_fetch_data;
  logic                 r_data_resp;
  logic [BUS_WIDTH-1:0] r_data_rdata;

  logic                 w_fetch_in_range;
  logic                 w_data_in_range;
  logic                 w_host_in_range;
  logic [AW-1:0]        w_fetch_idx;
  logic [AW-1:0]        w_data_idx;
  logic [AW-1:0]        w_host_idx;
  logic                 w_fetch_acc;
  logic                 w_data_acc;
  logic                 w_data_rd;
  logic                 w_host_wr;
  logic                 w_core_wr;
  logic                 w_wr_en;
  logic [AW-1:0]        w_wr_idx;
  logic [BUS_WIDTH-1:0] w_wr_data;

  assign w_fetch_in_range = bus.core_address_memory < MEM_LIMIT;
  assign w_data_in_range  = bus.core_address_memory_data < MEM_LIMIT;
  assign w_host_in_range  = bus.host_addr < MEM_LIMIT;
  assign w_fetch_idx      = bus.core_address_memory[OFF +: AW];
  assign w_data_idx       = bus.core_address_memory_data[OFF +: AW];
  assign w_host_idx       = bus.host_addr[OFF +: AW];

  assign w_fetch_acc = !r_reset_core && bus.core_read_memory;
  assign w_data_acc  = !r_reset_core && (bus.core_read_memory_data || bus.core_write_memory_data);
  assign w_data_rd   = w_data_acc && !bus.core_write_memory_data;

  // Host and core writes are mutually exclusive through reset_core, so one write port suffices.
  assign w_host_wr = r_reset_core && bus.host_we && w_host_in_range;
  assign w_core_wr = !r_reset_core && bus.core_write_memory_data && w_data_in_range;
  assign w_wr_en   = reset_n && (w_host_wr || w_core_wr);
  assign w_wr_idx  = r_reset_core ? w_host_idx : w_data_idx;
  assign w_wr_data = r_reset_core ? bus.host_wdata : bus.core_write_data_memory_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_COUNT;
      r_cnt        <= CW'(RESET_CLK_CYCLES);
      r_reset_core <= 1'b1;
    end else if (bus.host_hold) begin
      r_state      <= ST_COUNT;
      r_cnt        <= CW'(RESET_CLK_CYCLES);
      r_reset_core <= 1'b1;
    end else begin
      case (r_state)
        ST_COUNT: begin
          if (r_cnt <= CW'(1)) begin
            r_cnt        <= '0;
            r_state      <= ST_RUN;
            r_reset_core <= 1'b0;
          end else begin
            r_cnt        <= r_cnt - CW'(1);
            r_reset_core <= 1'b1;
          end
        end
        default: r_reset_core <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

  // Reads sample the array before this edge's write lands, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_resp <= 1'b0;
      r_fetch_data <= '0;
      r_data_resp  <= 1'b0;
      r_data_rdata <= '0;
    end else begin
      r_fetch_resp <= w_fetch_acc;
      r_data_resp  <= w_data_acc;
      if (w_fetch_acc) r_fetch_data <= w_fetch_in_range ? r_mem[w_fetch_idx] : '0;
      if (w_data_rd)   r_data_rdata <= w_data_in_range ? r_mem[w_data_idx] : '0;
    end
  end

  assign bus.reset_core                 = r_reset_core;
  assign bus.core_memory_response       = r_fetch_resp;
  assign bus.core_read_data_memory      = r_fetch_data;
  assign bus.core_memory_response_data  = r_data_resp;
  assign bus.core_read_data_memory_data = r_data_rdata;
endmodule

// File: tb/tb_processorci_core_controller.sv
// Scoreboard bench: a behavioural model queues expected responses at each edge,
// a negedge monitor pops and compares whatever the controller presents.
module tb_processorci_core_controller;
  localparam int RST_CYC = 20;
  localparam int MEM_SZ  = 4096;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    bit          known;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  processorci_core_controller_if #(.BUS_WIDTH(32)) bus ();

  processorci_core_controller #(
    .BUS_WIDTH(32), .WORD_SIZE_BY(4), .RESET_CLK_CYCLES(RST_CYC), .MEMORY_SIZE(MEM_SZ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [31:0] mm [MEM_SZ/4];
  bit          mk [MEM_SZ/4];
  exp_t        fq[$];
  exp_t        dq[$];
  bit          exp_rc = 1'b1;
  int unsigned quiet = 0;
  logic [31:0] last_drd = '0;
  bit          last_known = 1'b1;
  bit          old_rc, acc;
  exp_t        fe_m, de_m, fe, de;

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output bit k);
    if (a < MEM_SZ) begin
      d = mm[a[11:2]];
      k = mk[a[11:2]];
    end else begin
      d = '0;
      k = 1'b1;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a < MEM_SZ) begin
      mm[a[11:2]] = d;
      mk[a[11:2]] = 1'b1;
    end
  endtask

  // Reference model: what each edge should cause, in terms of the rules alone.
  always @(posedge clk) begin
    cyc++;
    old_rc = exp_rc;
    if (!reset_n) begin
      quiet = 0; exp_rc = 1'b1; last_drd = '0; last_known = 1'b1;
    end else begin
      acc = !old_rc;
      if (acc && bus.core_read_memory) begin
        fe_m.cyc = cyc;
        model_read(bus.core_address_memory, fe_m.data, fe_m.known);
        fq.push_back(fe_m);
      end
      if (acc && (bus.core_read_memory_data || bus.core_write_memory_data)) begin
        if (!bus.core_write_memory_data)
          model_read(bus.core_address_memory_data, last_drd, last_known);
        de_m.cyc = cyc; de_m.data = last_drd; de_m.known = last_known;
        dq.push_back(de_m);
      end
      if (old_rc && bus.host_we) model_write(bus.host_addr, bus.host_wdata);
      if (acc && bus.core_write_memory_data)
        model_write(bus.core_address_memory_data, bus.core_write_data_memory_data);
      if (bus.host_hold) quiet = 0;
      else if (quiet < RST_CYC) quiet++;
      exp_rc = bus.host_hold || (quiet < RST_CYC);
    end
  end

  always @(negedge reset_n) begin
    fq.delete(); dq.delete();
    exp_rc = 1'b1; quiet = 0; last_drd = '0; last_known = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    chk("reset_core", 32'(bus.reset_core), 32'(exp_rc));
    if (fq.size() > 0 && fq[0].cyc == cyc) begin
      fe = fq.pop_front();
      chk("fetch_resp", 32'(bus.core_memory_response), 32'd1);
      if (fe.known) chk("fetch_data", bus.core_read_data_memory, fe.data);
    end else chk("fetch_resp", 32'(bus.core_memory_response), 32'd0);
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      de = dq.pop_front();
      chk("data_resp", 32'(bus.core_memory_response_data), 32'd1);
      if (de.known) chk("data_rdata", bus.core_read_data_memory_data, de.data);
    end else chk("data_resp", 32'(bus.core_memory_response_data), 32'd0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.host_we = 1'b0;
    bus.core_read_memory = 1'b0;
    bus.core_read_memory_data = 1'b0;
    bus.core_write_memory_data = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    tick();
    bus.host_we = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (exp_rc && n < 3 * RST_CYC) begin
      tick();
      n++;
    end
    checks++;
    if (exp_rc) begin
      errors++;
      $display("FAIL wait_run timeout got=%0d want=%0d", n, RST_CYC);
    end
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
    bus.core_write_memory_data = 1'b1; bus.core_read_memory_data = 1'b0;
    bus.core_address_memory_data = a; bus.core_write_data_memory_data = d;
  endtask

  task automatic dread(input logic [31:0] a);
    bus.core_write_memory_data = 1'b0; bus.core_read_memory_data = 1'b1;
    bus.core_address_memory_data = a;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.core_read_memory = 1'b1; bus.core_address_memory = a;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 15);
    if (sel == 0) return 32'hFFFF_FFFF;
    if (sel == 1) return 32'h0000_1000 + ($urandom_range(0, 255) << 2);
    return ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    idle();
    bus.host_hold = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.core_address_memory = '0; bus.core_address_memory_data = '0;
    bus.core_write_data_memory_data = '0;

    // Power-up with fetch requests pending throughout the reset window.
    fetch(32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(RST_CYC + 3);
    idle();

    // Load image under hold.
    bus.host_hold = 1'b1;
    tick();
    for (int unsigned w = 0; w < 32; w++) host_write(w << 2, $urandom());
    host_write(32'h0, 32'h0000_0013);
    host_write(32'h4, 32'hDEAD_BEEF);
    bus.host_hold = 1'b0;
    wait_run();

    fetch(32'h0); tick();
    fetch(32'h4); tick();
    idle();

    // Data write then read-after-write.
    dwrite(32'h100, 32'hCAFE_BABE); tick();
    dread(32'h100); tick();
    idle(); tick();

    // Fetch/data-write collision: fetch sees old word, later fetch sees new.
    fetch(32'h100); dwrite(32'h100, 32'h1234_5678); tick();
    idle(); fetch(32'h100); tick();
    idle(); tick();

    // Out of range, aliasing, and read+write together.
    dread(32'h1000); tick();
    dwrite(32'h1000, 32'hBAD0_BAD0); tick();
    dread(32'h0); fetch(32'h1000); tick();
    idle();
    bus.core_read_memory_data = 1'b1; bus.core_write_memory_data = 1'b1;
    bus.core_address_memory_data = 32'h18; bus.core_write_data_memory_data = 32'h600D_F00D;
    tick();
    idle(); dread(32'h18); tick();
    idle(); tick(2);

    // Random traffic with periodic host hold windows.
    for (int i = 0; i < 400; i++) begin
      int unsigned op = $urandom_range(0, 3);
      bus.core_read_memory = 1'($urandom_range(0, 1));
      bus.core_address_memory = rand_addr();
      bus.core_read_memory_data = (op == 1 || op == 3);
      bus.core_write_memory_data = (op == 2 || op == 3);
      bus.core_address_memory_data = rand_addr();
      bus.core_write_data_memory_data = $urandom();
      bus.host_hold = (i % 100 >= 60) && (i % 100 < 64);
      bus.host_we = ($urandom_range(0, 3) == 0);
      bus.host_addr = rand_addr();
      bus.host_wdata = $urandom();
      tick();
    end
    idle(); bus.host_hold = 1'b0;
    wait_run();

    // reset_n asserted while a fetch response is outstanding and a write is requested.
    fetch(32'h0); tick();
    idle(); dwrite(32'h18, 32'h55AA_55AA);
    reset_n = 1'b0;
    tick(3);
    idle(); reset_n = 1'b1;
    wait_run();
    dread(32'h18); tick();
    idle(); tick(3);

    chk("pending", 32'(fq.size() + dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
